// File: rtl/clock_pkg.sv
// Shared constants, BCD field type and write validation for the time-of-day block.
package clock_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned HH_LSB  = 24;
  localparam int unsigned MM_LSB  = 16;
  localparam int unsigned SS_LSB  = 8;
  localparam int unsigned CS_LSB  = 0;

  typedef logic [FIELD_W-1:0] bcd2_t;

  localparam bcd2_t CS_MAX = 8'h99;
  localparam bcd2_t SS_MAX = 8'h59;
  localparam bcd2_t MM_MAX = 8'h59;
  localparam bcd2_t HH_MAX = 8'h23;

  // True when every nibble is a decimal digit and each field is in range.
  function automatic logic bcd_word_ok(input logic [WORD_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (w[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    if (w[HH_LSB +: FIELD_W] > HH_MAX) ok = 1'b0;
    if (w[MM_LSB +: FIELD_W] > MM_MAX) ok = 1'b0;
    if (w[SS_LSB +: FIELD_W] > SS_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rtc_bcd_word_if.sv
// CPU load path and display-side outputs of the time-of-day source.
interface rtc_bcd_word_if;
  import clock_pkg::*;

  logic              run;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              ce1ms;
  logic [WORD_W-1:0] word;
  logic              sec_tick;
  logic              day_tick;
  logic              wr_err;

  modport master (output run, wr_en, wr_data,
                  input  ce1ms, word, sec_tick, day_tick, wr_err);
  modport slave  (input  run, wr_en, wr_data,
                  output ce1ms, word, sec_tick, day_tick, wr_err);
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at MAX, with synchronous load taking priority.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h99
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t value,
  output logic  carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (value == MAX)            value <= '0;
      else if (value[3:0] == 4'd9) value <= {value[7:4] + 4'd1, 4'd0};
      else                         value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/rtc_bcd_word.sv
// ms prescaler plus HH:MM:SS.cc BCD clock packed into the scanner's nibble word.
module rtc_bcd_word
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  rtc_bcd_word_if.slave  bus
);

  localparam int unsigned MS_DIV = CLK_HZ / 1000;
  localparam int unsigned PW     = $clog2(MS_DIV);

  logic [PW-1:0] pcnt;
  logic          ce1ms_q;
  logic [3:0]    ms10;
  logic          sec_tick_q, day_tick_q, wr_err_q;

  logic  wr_ok, load, adv, cs_inc;
  bcd2_t cs, ss, mm, hh;
  logic  cs_carry, ss_carry, mm_carry, hh_carry;

  // Free-running prescaler; ce1ms follows the terminal count by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt    <= '0;
      ce1ms_q <= 1'b0;
    end else if (pcnt == PW'(MS_DIV - 1)) begin
      pcnt    <= '0;
      ce1ms_q <= 1'b1;
    end else begin
      pcnt    <= pcnt + PW'(1);
      ce1ms_q <= 1'b0;
    end
  end

  assign wr_ok  = bcd_word_ok(bus.wr_data);
  assign load   = bus.wr_en && wr_ok;
  assign adv    = ce1ms_q && bus.run;
  assign cs_inc = adv && (ms10 == 4'd9) && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ms10 <= '0;
    else if (load)   ms10 <= '0;
    else if (adv)    ms10 <= (ms10 == 4'd9) ? 4'd0 : ms10 + 4'd1;
  end

  bcd2_counter #(.MAX(CS_MAX)) u_cs (
    .clk(clk), .rst_n(rst_n), .inc(cs_inc), .load(load),
    .load_val(bus.wr_data[CS_LSB +: FIELD_W]), .value(cs), .carry(cs_carry));
  bcd2_counter #(.MAX(SS_MAX)) u_ss (
    .clk(clk), .rst_n(rst_n), .inc(cs_carry), .load(load),
    .load_val(bus.wr_data[SS_LSB +: FIELD_W]), .value(ss), .carry(ss_carry));
  bcd2_counter #(.MAX(MM_MAX)) u_mm (
    .clk(clk), .rst_n(rst_n), .inc(ss_carry), .load(load),
    .load_val(bus.wr_data[MM_LSB +: FIELD_W]), .value(mm), .carry(mm_carry));
  bcd2_counter #(.MAX(HH_MAX)) u_hh (
    .clk(clk), .rst_n(rst_n), .inc(mm_carry), .load(load),
    .load_val(bus.wr_data[HH_LSB +: FIELD_W]), .value(hh), .carry(hh_carry));

  // Carries are already blocked on load edges, so loads never raise ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      sec_tick_q <= cs_carry;
      day_tick_q <= hh_carry;
      wr_err_q   <= bus.wr_en && !wr_ok;
    end
  end

  assign bus.ce1ms    = ce1ms_q;
  assign bus.word     = {hh, mm, ss, cs};
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_tick = day_tick_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_rtc_bcd_word.sv
// Scoreboard bench: a centisecond-count time model predicts every output cycle.
module tb_rtc_bcd_word;

  localparam int MS_DIV = 10;
  localparam int DAY_CS = 24 * 3600 * 100;

  typedef struct {
    logic [31:0] word;
    bit ce, sec, day, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rtc_bcd_word_if bus();

  rtc_bcd_word #(.CLK_HZ(10_000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  int m_pcnt = 0, m_ms10 = 0, m_total = 0, m_adv = 0;
  bit m_ce = 0;
  int n_ce = 0, n_sec = 0, n_day = 0, n_err = 0, n_same = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic logic [31:0] to_word(input int t);
    int s;
    s = t / 100;
    return {bcd(s / 3600), bcd((s / 60) % 60), bcd(s % 60), bcd(t % 100)};
  endfunction

  // Decode a word into a centisecond count; returns 0 if it is not a legal time.
  function automatic bit decode(input logic [31:0] w, output int t);
    int d[8];
    int hh, mm, ss, cs;
    logic [31:0] v;
    v = w;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(v & 32'hF);
      v = v >> 4;
      if (d[i] > 9) return 1'b0;
    end
    cs = d[1] * 10 + d[0];
    ss = d[3] * 10 + d[2];
    mm = d[5] * 10 + d[4];
    hh = d[7] * 10 + d[6];
    if (hh > 23 || mm > 59 || ss > 59) return 1'b0;
    t = ((hh * 60 + mm) * 60 + ss) * 100 + cs;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pcnt = 0; m_ms10 = 0; m_total = 0; m_ce = 0;
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, wait one cycle.
  task automatic step(input bit r, input bit we, input logic [31:0] wd);
    exp_t e;
    int t, old;
    bit ok;
    bus.run = r; bus.wr_en = we; bus.wr_data = wd;
    ok = decode(wd, t);
    e.sec = 0; e.day = 0;
    e.err = we && !ok;
    if (we && ok) begin
      m_total = t;
      m_ms10 = 0;
    end else if (m_ce && r) begin
      m_adv++;
      if (m_ms10 == 9) begin
        m_ms10 = 0;
        old = m_total;
        m_total = (m_total + 1) % DAY_CS;
        e.sec = (old / 100) != (m_total / 100);
        e.day = (m_total == 0);
      end else begin
        m_ms10++;
      end
    end
    e.ce = (m_pcnt == MS_DIV - 1);
    m_ce = e.ce;
    m_pcnt = (m_pcnt + 1) % MS_DIV;
    e.word = to_word(m_total);
    exp_q.push_back(e);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic run_pulses(input int n);
    int target;
    target = m_adv + n;
    for (int k = 0; k < (n + 2) * MS_DIV && m_adv < target; k++) step(1'b1, 1'b0, 32'h0);
    chk("pulse_budget", 32'(m_adv), 32'(target));
  endtask

  // Monitor: compare DUT outputs with the oldest prediction after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (bus.ce1ms) n_ce++;
      if (bus.sec_tick) n_sec++;
      if (bus.day_tick) n_day++;
      if (bus.wr_err) n_err++;
      if (bus.sec_tick && bus.day_tick) n_same++;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("word", bus.word, e.word);
      chk("ce1ms", 32'(bus.ce1ms), 32'(e.ce));
      chk("sec_tick", 32'(bus.sec_tick), 32'(e.sec));
      chk("day_tick", 32'(bus.day_tick), 32'(e.day));
      chk("wr_err", 32'(bus.wr_err), 32'(e.err));
    end
  end

  initial begin
    int c0, s0, d0, e0, sm0;
    logic [31:0] bad_w[3];
    bus.run = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 32'h0;
    #17;
    chk("rst_word", bus.word, 32'h0);
    chk("rst_ce1ms", 32'(bus.ce1ms), 32'h0);
    chk("rst_sec", 32'(bus.sec_tick), 32'h0);
    chk("rst_day", 32'(bus.day_tick), 32'h0);
    chk("rst_err", 32'(bus.wr_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Frozen time, scan strobe still running.
    c0 = n_ce;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 32'h0);
    chk("frozen_ce_count", 32'(n_ce - c0), 32'd5);
    chk("frozen_word", bus.word, 32'h0);

    // Free run into centiseconds and then the first second.
    run_pulses(100);
    chk("cs10", bus.word, 32'h00000010);
    s0 = n_sec;
    run_pulses(900);
    chk("sec1", bus.word, 32'h00000100);
    chk("sec1_ticks", 32'(n_sec - s0), 32'd1);

    // Day rollover.
    step(1'b1, 1'b1, 32'h23595999);
    chk("load_2359", bus.word, 32'h23595999);
    s0 = n_sec; d0 = n_day; sm0 = n_same;
    run_pulses(10);
    chk("rollover_word", bus.word, 32'h0);
    chk("rollover_day", 32'(n_day - d0), 32'd1);
    chk("rollover_sec", 32'(n_sec - s0), 32'd1);
    chk("rollover_same", 32'(n_same - sm0), 32'd1);

    // Rejected writes leave the time alone.
    step(1'b0, 1'b1, 32'h01020304);
    bad_w[0] = 32'h24000000; bad_w[1] = 32'h00600000; bad_w[2] = 32'h0000005A;
    for (int i = 0; i < 3; i++) begin
      e0 = n_err;
      step(1'b0, 1'b1, bad_w[i]);
      step(1'b0, 1'b0, 32'h0);
      chk("bad_write_word", bus.word, 32'h01020304);
      chk("bad_write_err", 32'(n_err - e0), 32'd1);
    end

    // Async reset while ce1ms is high.
    for (int k = 0; k < 2 * MS_DIV && !m_ce; k++) step(1'b0, 1'b0, 32'h0);
    chk("pre_reset_ce", 32'(bus.ce1ms), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_word", bus.word, 32'h0);
    chk("async_rst_ce", 32'(bus.ce1ms), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = n_ce;
    for (int i = 0; i < MS_DIV; i++) step(1'b0, 1'b0, 32'h0);
    chk("post_rst_ce", 32'(n_ce - c0), 32'd1);
    chk("post_rst_ce_now", 32'(bus.ce1ms), 32'd1);

    // Write lands exactly on the 42->43 centisecond edge.
    for (int k = 0; k < 6000 && !(m_ce && m_ms10 == 9 && (m_total % 100) == 42); k++)
      step(1'b1, 1'b0, 32'h0);
    chk("cs42_reached", bus.word, 32'h00000042);
    step(1'b1, 1'b1, 32'h12345600);
    chk("collide_word", bus.word, 32'h12345600);
    run_pulses(9);
    chk("ms10_restart_hold", bus.word, 32'h12345600);
    run_pulses(1);
    chk("ms10_restart_inc", bus.word, 32'h12345601);

    // Random run/write traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, we;
      logic [31:0] d;
      r  = ($urandom % 4) != 0;
      we = ($urandom % 40) == 0;
      if ($urandom % 2)
        d = {bcd($urandom_range(0, 23)), bcd($urandom_range(0, 59)),
             bcd($urandom_range(0, 59)), bcd($urandom_range(0, 99))};
      else
        d = $urandom;
      step(r, we, d);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bcd_word.md
Name: rtc_bcd_word

Overview:
- Time-of-day source that sits directly upstream of the 8-digit seven-segment scanner.
- Divides the system clock to produce the 1 ms scan strobe (ce1ms) and keeps an HH:MM:SS.cc time in BCD.
- Packs the time into the 32-bit nibble word the scanner shows.
- The CPU side can load a new time through a single-cycle write strobe; invalid BCD is rejected.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; must be a multiple of 1000 and ≥ 2000.
- MS_DIV, CLK_HZ/1000 (derived localparam), clock cycles per ms strobe.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = time advances; 0 = time frozen (ce1ms keeps running)
- wr_en  in  1  single-cycle load strobe
- wr_data  in  32  new time in word format (below)
- ce1ms  out  1  one-cycle pulse every MS_DIV clocks; drives display scan
- word  out  32  {hh[31:24], mm[23:16], ss[15:8], cs[7:0]}, each field 2-digit BCD
- sec_tick  out  1  one-cycle pulse when ss increments or wraps
- day_tick  out  1  one-cycle pulse on 23:59:59.99 → 00:00:00.00
- wr_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0, ms10=0, all fields 00.
  - word=32'h0, ce1ms=0, sec_tick=0, day_tick=0, wr_err=0.
  - Release is synchronous to the next clk edge.
- Prescaler:
  - Counts 0..MS_DIV-1 and wraps.
  - ce1ms is registered and high for exactly the cycle after the count reaches MS_DIV-1, so the period is MS_DIV clocks.
  - Runs independently of run and wr_en; a write never resets it.
- ms10 counter:
  - 0..9, advances on edges where ce1ms=1 and run=1.
  - When ms10==9, the advance wraps it to 0 and increments cs.
- Field chain (all BCD; low digit 0-9, carry into high digit):
  - cs 00..99, wrap → ss+1.
  - ss 00..59, wrap → mm+1.
  - mm 00..59, wrap → hh+1.
  - hh 00..23, wrap to 00.
  - The whole chain updates on a single edge; word reflects it the following cycle.
- Tick outputs:
  - sec_tick is asserted in the same cycle that word first shows the new ss.
  - day_tick is asserted in the same cycle that word first shows 32'h0 from rollover.
- Write:
  - Valid when every nibble is ≤ 9, hh ≤ 8'h23, mm ≤ 8'h59 and ss ≤ 8'h59.
  - A valid write loads all four fields and clears ms10 on that edge; word = wr_data the next cycle.
  - An invalid write changes nothing, and wr_err pulses the next cycle.
  - A write on the same edge as an increment wins; the increment is discarded.
  - A load never generates sec_tick or day_tick.
  - Writes are accepted regardless of run.
- run=0: fields and ms10 hold; ce1ms continues.
- Reset asserted mid-count: everything returns to reset values immediately.

Decomposition:
- Package clock_pkg holds:
  - field widths and word bit positions (HH_LSB=24, MM_LSB=16, SS_LSB=8, CS_LSB=0);
  - BCD limits (CS_MAX=8'h99, SS_MAX=8'h59, MM_MAX=8'h59, HH_MAX=8'h23);
  - the 2-digit BCD field typedef.
- One sub-module: bcd2_counter.
  - Parameter MAX.
  - Inputs: clk, rst_n, inc, load, load_val.
  - Outputs: value[7:0], carry (= inc && value==MAX).
  - Instantiated four times in a carry chain.

Test Plan (CLK_HZ=10_000 → MS_DIV=10):
- Reset release, run=0 → ce1ms pulses every 10 clocks, high 1 cycle; word stays 32'h00000000.
- run=1 from reset for 100 ce1ms pulses → word=32'h00000010 (cs=10); 1000 pulses → 32'h00000100 with exactly one sec_tick.
- Write 32'h23595999, run=1, 10 ce1ms pulses → word=32'h00000000, day_tick and sec_tick pulse once in the same cycle.
- Invalid writes 32'h24000000, 32'h00600000 and 32'h0000005A → word unchanged, wr_err pulses once each.
- wr_en on the exact edge where cs would go 42→43, data 32'h12345600 → word=32'h12345600, no 43, ms10 restarts at 0.
- rst_n low mid-count at word=32'h01020304 → word=0 and ce1ms=0 asynchronously; prescaler restarts at 0 after release.
